// File: rtl/mbssoc_int_sched.sv
// Two-core interrupt scheduler: edge-detected device requests are latched as pending,
// routed per core, offered with a valid/take handshake and held in service until EOI.
module mbssoc_int_sched #(
  parameter int NSRC  = 5,
  parameter int NUM_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  irq,
  output logic [NSRC-1:0]  irq_ack,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic [1:0]       core_ready,
  output logic [1:0]       int_valid,
  output logic [NUM_W-1:0] int_num0,
  output logic [NUM_W-1:0] int_num1,
  input  logic [1:0]       int_take,
  input  logic [1:0]       int_eoi,
  output logic [1:0]       busy
);

  // Handshake: a core's offer is live while int_valid[c]=1; it completes on the cycle
  // int_take[c]=1 is sampled with int_valid[c]=1, and the number stays stable until then.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OFFER   = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  function automatic logic [NSRC-1:0] num_to_mask(input logic [NUM_W-1:0] num);
    logic [NSRC-1:0] m;
    m = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (num == NUM_W'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [NUM_W-1:0] lowest_num(input logic [NSRC-1:0] m);
    logic [NUM_W-1:0] n;
    n = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (m[i]) n = NUM_W'(i + 1);
    end
    return n;
  endfunction

  logic [NSRC-1:0]  irq_q, rst_mask_q, pend_q, pend_d;
  logic [NSRC-1:0]  route0_q, route1_q, ack_q, ack_d, edge_v;
  logic             en_q, rr_q, rr_d, conflict;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [NUM_W-1:0] num_q [2];
  logic [NUM_W-1:0] num_d [2];
  logic [NUM_W-1:0] win [2];
  logic [NUM_W-1:0] pick [2];
  logic [NSRC-1:0]  claim [2];
  logic [NSRC-1:0]  cand [2];
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NSRC];

  // A source held (offered or in service) by one core is invisible to the other.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      claim[c] = (state_q[c] != S_IDLE) ? num_to_mask(num_q[c]) : '0;
    end
    cand[0] = pend_q & route0_q & ~claim[1];
    cand[1] = pend_q & route1_q & ~claim[0];
    for (int c = 0; c < 2; c++) begin
      win[c] = (state_q[c] == S_IDLE && en_q && core_ready[c]) ? lowest_num(cand[c]) : '0;
    end
    conflict = (win[0] != '0) && (win[0] == win[1]);
    pick[0]  = win[0];
    pick[1]  = win[1];
    rr_d     = rr_q;
    if (conflict) begin
      rr_d = ~rr_q;
      if (!rr_q) pick[1] = lowest_num(cand[1] & ~num_to_mask(win[0]));
      else       pick[0] = lowest_num(cand[0] & ~num_to_mask(win[1]));
    end
  end

  always_comb begin
    ack_d = '0;
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      num_d[c]   = num_q[c];
      case (state_q[c])
        S_IDLE: begin
          if (pick[c] != '0) begin
            state_d[c] = S_OFFER;
            num_d[c]   = pick[c];
          end
        end
        S_OFFER: begin
          // A take beats a simultaneous withdrawal.
          if (int_take[c]) begin
            state_d[c] = S_SERVICE;
            ack_d      = ack_d | num_to_mask(num_q[c]);
          end else if (!core_ready[c] || !en_q) begin
            state_d[c] = S_IDLE;
            num_d[c]   = '0;
          end
        end
        S_SERVICE: begin
          if (int_eoi[c]) begin
            state_d[c] = S_IDLE;
            num_d[c]   = '0;
          end
        end
        default: begin
          state_d[c] = S_IDLE;
          num_d[c]   = '0;
        end
      endcase
    end
    // rst_mask_q hides levels that were already high across reset release.
    edge_v = irq & ~irq_q & ~rst_mask_q;
    pend_d = (pend_q & ~ack_d) | edge_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q      <= '0;
      rst_mask_q <= irq;
      pend_q     <= '0;
      route0_q   <= '1;
      route1_q   <= '0;
      en_q       <= 1'b0;
      rr_q       <= 1'b0;
      ack_q      <= '0;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= S_IDLE;
        num_q[c]   <= '0;
      end
    end else begin
      irq_q      <= irq;
      rst_mask_q <= '0;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        num_q[c]   <= num_d[c];
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    route0_q <= cfg_wdata[NSRC-1:0];
          2'd1:    route1_q <= cfg_wdata[NSRC-1:0];
          2'd2:    en_q     <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign int_valid[0] = (state_q[0] == S_OFFER);
  assign int_valid[1] = (state_q[1] == S_OFFER);
  assign busy[0]      = (state_q[0] == S_SERVICE);
  assign busy[1]      = (state_q[1] == S_SERVICE);
  assign int_num0     = num_q[0];
  assign int_num1     = num_q[1];
  assign irq_ack      = ack_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[NSRC-1:0] = route0_q;
      2'd1: cfg_rdata[NSRC-1:0] = route1_q;
      2'd2: cfg_rdata[0]        = en_q;
      default: begin
        cfg_rdata[NSRC-1:0] = pend_q;
        cfg_rdata[17:16]    = busy;
        cfg_rdata[25:24]    = int_valid;
      end
    endcase
  end

endmodule

// File: tb/tb_mbssoc_int_sched.sv
// Directed bench for mbssoc_int_sched: a queue-based scheduling model checked every
// cycle, plus literal expectations along the scenario.
module tb_mbssoc_int_sched;
  localparam int NSRC  = 5;
  localparam int NUM_W = 3;

  logic             clk, rst, cfg_we;
  logic [NSRC-1:0]  irq, irq_ack;
  logic [1:0]       cfg_addr, core_ready, int_valid, int_take, int_eoi, busy;
  logic [31:0]      cfg_wdata, cfg_rdata;
  logic [NUM_W-1:0] int_num0, int_num1;

  int tests_run = 0;
  int tests_failed = 0;

  mbssoc_int_sched #(.NSRC(NSRC), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_ack(irq_ack),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .core_ready(core_ready), .int_valid(int_valid), .int_num0(int_num0), .int_num1(int_num1),
    .int_take(int_take), .int_eoi(int_eoi), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: m_src[c] is the source a core holds (-1 none), m_svc[c] says it is in service.
  logic [NSRC-1:0] m_pend, m_prev, m_mask, m_ack, m_route0, m_route1;
  bit              m_en, m_rr, model_live;
  int              m_src [2];
  bit              m_svc [2];
  int              q0[$], q1[$];

  always @(posedge clk) begin : model
    int              nsrc [2];
    bit              nsvc [2];
    logic [NSRC-1:0] nack;
    model_live = 1'b1;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_mask = irq; m_ack = '0;
      m_route0 = '1; m_route1 = '0; m_en = 1'b0; m_rr = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_src[c] = -1;
        m_svc[c] = 1'b0;
      end
    end else begin
      nack = '0;
      for (int c = 0; c < 2; c++) begin
        nsrc[c] = m_src[c];
        nsvc[c] = m_svc[c];
        if (m_svc[c]) begin
          if (int_eoi[c]) begin
            nsvc[c] = 1'b0;
            nsrc[c] = -1;
          end
        end else if (m_src[c] >= 0) begin
          if (int_take[c]) begin
            nsvc[c] = 1'b1;
            nack[m_src[c]] = 1'b1;
          end else if (!core_ready[c] || !m_en) begin
            nsrc[c] = -1;
          end
        end
      end
      q0.delete();
      q1.delete();
      for (int i = 0; i < NSRC; i++) begin
        if (m_pend[i]) begin
          if (m_src[0] < 0 && m_en && core_ready[0] && m_route0[i] && m_src[1] != i) q0.push_back(i);
          if (m_src[1] < 0 && m_en && core_ready[1] && m_route1[i] && m_src[0] != i) q1.push_back(i);
        end
      end
      if (q0.size() > 0 && q1.size() > 0 && q0[0] == q1[0]) begin
        if (!m_rr) begin
          nsrc[0] = q0[0];
          if (q1.size() > 1) nsrc[1] = q1[1];
        end else begin
          nsrc[1] = q1[0];
          if (q0.size() > 1) nsrc[0] = q0[1];
        end
        m_rr = !m_rr;
      end else begin
        if (q0.size() > 0) nsrc[0] = q0[0];
        if (q1.size() > 0) nsrc[1] = q1[0];
      end
      m_pend = (m_pend & ~nack) | (irq & ~m_prev & ~m_mask);
      m_prev = irq;
      m_mask = '0;
      m_ack  = nack;
      if (cfg_we) begin
        if (cfg_addr == 2'd0) m_route0 = cfg_wdata[NSRC-1:0];
        if (cfg_addr == 2'd1) m_route1 = cfg_wdata[NSRC-1:0];
        if (cfg_addr == 2'd2) m_en = cfg_wdata[0];
      end
      for (int c = 0; c < 2; c++) begin
        m_src[c] = nsrc[c];
        m_svc[c] = nsvc[c];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0]  e_valid, e_busy;
    logic [31:0] e_num [2];
    logic [31:0] e_rd;
    if (model_live) begin
      for (int c = 0; c < 2; c++) begin
        e_valid[c] = (m_src[c] >= 0) && !m_svc[c];
        e_busy[c]  = m_svc[c];
        e_num[c]   = (m_src[c] >= 0) ? 32'(m_src[c] + 1) : 32'd0;
      end
      case (cfg_addr)
        2'd0:    e_rd = 32'(m_route0);
        2'd1:    e_rd = 32'(m_route1);
        2'd2:    e_rd = 32'(m_en);
        default: e_rd = 32'(m_pend) | (32'(e_busy) << 16) | (32'(e_valid) << 24);
      endcase
      chk("cyc_int_valid", 32'(int_valid), 32'(e_valid));
      chk("cyc_busy", 32'(busy), 32'(e_busy));
      chk("cyc_int_num0", 32'(int_num0), e_num[0]);
      chk("cyc_int_num1", 32'(int_num1), e_num[1]);
      chk("cyc_irq_ack", 32'(irq_ack), 32'(m_ack));
      chk("cyc_cfg_rdata", cfg_rdata, e_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 5'b01000; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    core_ready = 2'b00; int_take = 2'b00; int_eoi = 2'b00;
    repeat (3) tick();
    chk("rst_valid", 32'(int_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(irq_ack), 32'h0);
    rst = 1'b0;
    tick();
    chk("route0_after_rst", cfg_rdata, 32'h1F);
    cfg_addr = 2'd2; #1;
    chk("ctrl_after_rst", cfg_rdata, 32'h0);
    cfg_addr = 2'd3;
    tick();
    chk("held_irq_no_pend", cfg_rdata, 32'h0);
    irq = '0;

    // single-core offer, take, eoi
    cfg_write(2'd2, 32'h1);
    core_ready = 2'b01; irq[2] = 1'b1;
    tick();
    chk("no_valid_at_pend", 32'(int_valid), 32'h0);
    tick();
    chk("valid_two_cycles", 32'(int_valid), 32'h1);
    chk("num0_src2", 32'(int_num0), 32'd3);
    int_take = 2'b01; tick(); int_take = 2'b00;
    chk("ack_src2", 32'(irq_ack), 32'h04);
    chk("busy_core0", 32'(busy), 32'h1);
    tick();
    chk("ack_one_cycle", 32'(irq_ack), 32'h0);
    chk("num0_held_service", 32'(int_num0), 32'd3);
    int_eoi = 2'b01; tick(); int_eoi = 2'b00;
    chk("eoi_idle", 32'(busy), 32'h0);
    repeat (2) tick();
    chk("level_no_reoffer", 32'(int_valid), 32'h0);
    irq = '0;

    // conflict arbitration with round-robin swap
    cfg_write(2'd1, 32'h1F);
    core_ready = 2'b11; irq = 5'b00011;
    tick(); tick();
    chk("rr0_valid", 32'(int_valid), 32'h3);
    chk("rr0_num0", 32'(int_num0), 32'd1);
    chk("rr0_num1", 32'(int_num1), 32'd2);
    int_take = 2'b11; tick(); int_take = 2'b00;
    chk("dual_ack", 32'(irq_ack), 32'h03);
    int_eoi = 2'b11; tick(); int_eoi = 2'b00; irq = '0;
    tick();
    irq = 5'b00011;
    tick(); tick();
    chk("rr1_num0", 32'(int_num0), 32'd2);
    chk("rr1_num1", 32'(int_num1), 32'd1);
    int_take = 2'b11; tick(); int_take = 2'b00;
    int_eoi = 2'b11; tick(); int_eoi = 2'b00; irq = '0;

    // withdrawal on ready drop, repeat, take beats withdrawal
    core_ready = 2'b01; cfg_addr = 2'd3; irq[3] = 1'b1;
    tick(); tick();
    chk("src3_offer", 32'(int_num0), 32'd4);
    core_ready = 2'b00; tick();
    chk("withdraw_valid", 32'(int_valid), 32'h0);
    chk("withdraw_num", 32'(int_num0), 32'd0);
    chk("withdraw_pend_kept", cfg_rdata, 32'h0000_0008);
    core_ready = 2'b01; tick();
    chk("reoffer_num", 32'(int_num0), 32'd4);
    chk("reoffer_status", cfg_rdata, 32'h0100_0008);
    int_take = 2'b01; core_ready = 2'b00; tick(); int_take = 2'b00;
    chk("take_wins_busy", 32'(busy), 32'h1);
    chk("take_wins_ack", 32'(irq_ack), 32'h08);
    core_ready = 2'b01; int_eoi = 2'b01; tick(); int_eoi = 2'b00; irq = '0;

    // second edge during service, re-offered only after eoi
    irq[4] = 1'b1; tick(); tick();
    chk("src4_offer", 32'(int_num0), 32'd5);
    int_take = 2'b01; tick(); int_take = 2'b00;
    irq[4] = 1'b0; tick();
    irq[4] = 1'b1; core_ready = 2'b11; tick();
    repeat (2) tick();
    chk("no_offer_in_service", 32'(int_valid), 32'h0);
    chk("status_pend_busy", cfg_rdata, 32'h0001_0010);
    int_eoi = 2'b01; tick(); int_eoi = 2'b00;
    chk("no_offer_at_eoi", 32'(int_valid), 32'h0);
    tick();
    chk("src4_reoffer_valid", 32'(int_valid), 32'h1);
    chk("src4_reoffer_num", 32'(int_num0), 32'd5);
    int_take = 2'b01; tick(); int_take = 2'b00;
    int_eoi = 2'b01; tick(); int_eoi = 2'b00; irq = '0;

    // route change during offer, stray eoi ignored
    core_ready = 2'b01; irq[0] = 1'b1; tick(); tick();
    chk("src0_offer", 32'(int_num0), 32'd1);
    cfg_write(2'd0, 32'h0);
    chk("route_write_keeps_offer", 32'(int_valid), 32'h1);
    cfg_addr = 2'd3;
    int_eoi = 2'b01; tick(); int_eoi = 2'b00;
    chk("eoi_in_offer_ignored", 32'(int_valid), 32'h1);
    core_ready = 2'b00; tick();
    core_ready = 2'b01; tick(); tick();
    chk("route0_cleared", 32'(int_valid), 32'h0);
    core_ready = 2'b10; tick();
    chk("core1_takes_src0", 32'(int_num1), 32'd1);
    int_take = 2'b10; tick(); int_take = 2'b00;
    chk("core1_busy", 32'(busy), 32'h2);

    // reset in the middle of service
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(int_valid), 32'h0);
    chk("midrst_num1", 32'(int_num1), 32'h0);
    #1 chk("midrst_status", cfg_rdata, 32'h0);
    cfg_addr = 2'd0; #1;
    chk("midrst_route0", cfg_rdata, 32'h1F);
    cfg_addr = 2'd3; tick();
    chk("midrst_no_pend", cfg_rdata, 32'h0);

    // disabling EN withdraws an offer
    irq = '0;
    cfg_write(2'd2, 32'h1);
    irq[1] = 1'b1; core_ready = 2'b01; tick(); tick();
    chk("en_offer", 32'(int_num0), 32'd2);
    cfg_write(2'd2, 32'h0);
    chk("en_write_edge", 32'(int_valid), 32'h1);
    tick();
    chk("en_off_withdraws", 32'(int_valid), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mbssoc_int_sched.md
MBSSOC_INT_SCHED -- requirements
Module: MBSsoc_int_sched

Interface
REQ-001 SHALL have parameter NSRC, default 5: number of device interrupt sources (0=keyboard, 1=mouse, 2=uart, 3=storage, 4=ethernet).
REQ-002 SHALL have parameter NUM_W, default 3: interrupt-number width. Number 0 means "none"; source i is reported as i+1.
REQ-003 SHALL have one clock `clk`; reset `rst` is synchronous and active-high; both are decided and fixed.
REQ-004 Ports, in order:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- irq  in  NSRC  device level requests
- irq_ack  out  NSRC  one-cycle service-grant pulse per source
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  register select
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  combinational read data
- core_ready  in  2  per-core interrupt-enable (core may accept)
- int_valid  out  2  per-core offer valid
- int_num0  out  NUM_W  core0 offered number
- int_num1  out  NUM_W  core1 offered number
- int_take  in  2  per-core offer accept
- int_eoi  in  2  per-core end-of-interrupt pulse
- busy  out  2  per-core in-service flag

Function
REQ-005 Registers:
- addr0 ROUTE0[NSRC-1:0]: sources core0 may take.
- addr1 ROUTE1: the same for core1.
- addr2 CTRL bit0 EN: global enable.
- addr3 STATUS, read-only: [NSRC-1:0] pending, [17:16] busy, [25:24] int_valid.
- Unused read bits are 0; writes to addr3 are ignored.
REQ-006 irq SHALL be registered (irq_q). pend[i] is set when irq[i] & ~irq_q[i]: one cycle after irq first sampled high. Level-held irq SHALL NOT re-set pend.
REQ-007 pend[i] SHALL clear in the cycle after int_take accepts source i. If a new edge coincides with the clear, pend stays set.
REQ-008 Each core SHALL run an independent FSM with states IDLE, OFFER, SERVICE.
REQ-009 IDLE->OFFER when all of the following hold: EN=1, core_ready[c]=1, and some i has pend[i] & ROUTEc[i] and is not offered to or in service on the other core. The lowest such i wins (fixed priority). int_num latches i+1.
REQ-010 OFFER: int_valid[c]=1 and int_num stable. Transitions:
- int_take[c] -> SERVICE; irq_ack[i]=1 for exactly the next cycle.
- core_ready[c]=0 or EN=0 while no int_take -> IDLE; pend kept; number restored to 0.
- int_take has priority over withdrawal in the same cycle.
REQ-011 SERVICE: busy[c]=1, int_valid[c]=0, int_num holds its value. Source i SHALL NOT be re-offered to any core until int_eoi[c] returns the FSM to IDLE. EN=0 does not abort SERVICE.
REQ-012 Conflict: both cores in IDLE select the same winning source. That source goes to core rr. The other core evaluates the next eligible source in the same cycle, or stays IDLE if none. rr toggles after each conflict.
REQ-013 int_take or int_eoi received in a state that does not expect it SHALL be ignored.
REQ-014 Latency: irq rise sampled at edge k -> pend after k -> int_valid after k+1, when the core is idle and eligible.
REQ-015 A ROUTE write during OFFER SHALL NOT withdraw the current offer; it takes effect at the next IDLE evaluation.
REQ-016 Registers SHALL be written on the clk edge where cfg_we=1; the new value is visible on cfg_rdata the next cycle.

Reset
REQ-017 While rst=1 at a clk edge, the block SHALL load the following, overriding any operation in progress:
- ROUTE0 = all ones; ROUTE1 = 0; EN = 0.
- pend = 0; irq_q = 0; rr = 0; both FSMs = IDLE.
- irq_ack = 0; int_valid = 0; int_num0 = int_num1 = 0; busy = 0.
REQ-018 Requests whose irq is high through reset release SHALL NOT create pend; only a later rising edge does.

Verification
REQ-019 Setup EN=1, core_ready=01. irq[2] rises -> int_valid[0] two cycles later with int_num0=3. Assert int_take[0] -> irq_ack=00100 for one cycle, busy[0]=1. Then int_eoi[0] -> IDLE.
REQ-020 Set ROUTE1=all ones, core_ready=11. irq[0] and irq[1] rise together -> core0 gets num 1 and core1 gets num 2 (rr=0). Repeat -> roles swap.
REQ-021 Drop core_ready[0] while in OFFER -> int_valid[0]=0, pend kept. Restore core_ready[0] -> the offer is repeated.
REQ-022 irq[4] held high with no new edge -> offered once only. Pulse a second edge during SERVICE -> re-offered only after int_eoi.
REQ-023 Assert rst mid-SERVICE -> all outputs 0 next cycle and STATUS=0. CTRL reads 0; ROUTE0 reads 0x1F.
REQ-024 int_take in the same cycle as core_ready falls -> take wins; irq_ack pulse is issued.
